// File: rtl/wb_l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with 16-byte lines.
// Wishbone slave toward the CPU and wishbone master toward memory; every transfer moves a whole line.
module wb_l1_cache #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [11:0]  cpu_adr,
  input  logic [127:0] cpu_dat_m,
  output logic [127:0] cpu_dat_s,
  input  logic [15:0]  cpu_sel,
  input  logic         cpu_stb,
  input  logic         cpu_cyc,
  input  logic         cpu_we,
  output logic         cpu_ack,
  output logic         cpu_rty,
  output logic [11:0]  mem_adr,
  output logic [127:0] mem_dat_m,
  input  logic [127:0] mem_dat_s,
  output logic [15:0]  mem_sel,
  output logic         mem_stb,
  output logic         mem_cyc,
  output logic         mem_we,
  input  logic         mem_ack
);
  localparam int IDX = $clog2(NUM_SETS);
  localparam int TAG = 12 - IDX;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] WB    = 2'd2;
  localparam logic [1:0] FILL  = 2'd3;

  logic [1:0]          state;
  logic [11:0]         req_adr;
  logic [127:0]        req_dat_m;
  logic [15:0]         req_sel;
  logic                req_we;
  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TAG-1:0]      tag_mem  [NUM_SETS];
  logic [127:0]        data_mem [NUM_SETS];

  logic [IDX-1:0] idx;
  logic [TAG-1:0] req_tag;
  logic [127:0]   line;
  logic [127:0]   merged;
  logic           hit;

  assign idx     = req_adr[IDX-1:0];
  assign req_tag = req_adr[11:IDX];
  assign line    = data_mem[idx];
  assign hit     = valid[idx] && (tag_mem[idx] == req_tag);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    merged = line;
    for (int b = 0; b < 16; b++) begin
      if (req_sel[b]) merged[8*b +: 8] = req_dat_m[8*b +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_stb && cpu_cyc) state <= CHECK;
        end
        CHECK: begin
          if (hit) begin
            if (req_we) dirty[idx] <= 1'b1;
            state <= IDLE;
          end else if (valid[idx] && dirty[idx]) begin
            state <= WB;
          end else begin
            state <= FILL;
          end
        end
        WB: begin
          if (mem_ack) begin
            dirty[idx] <= 1'b0;
            state      <= FILL;
          end
        end
        FILL: begin
          if (mem_ack) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            state      <= CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag/data arrays and request registers carry no reset; valid bits gate any use of them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && cpu_stb && cpu_cyc) begin
        req_adr   <= cpu_adr;
        req_dat_m <= cpu_dat_m;
        req_sel   <= cpu_sel;
        req_we    <= cpu_we;
      end
      if (state == CHECK && hit && req_we) data_mem[idx] <= merged;
      if (state == FILL && mem_ack) begin
        data_mem[idx] <= mem_dat_s;
        tag_mem[idx]  <= req_tag;
      end
    end
  end

  // Write hits return the pre-merge line; the merge lands on the same edge the ack completes.
  always_comb begin
    cpu_ack   = (state == CHECK) && hit;
    cpu_dat_s = cpu_ack ? line : '0;
    mem_stb   = (state == WB) || (state == FILL);
    mem_we    = (state == WB);
    mem_adr   = (state == WB) ? {tag_mem[idx], idx} : req_adr;
    mem_dat_m = line;
  end

  assign cpu_rty = 1'b0;
  assign mem_cyc = mem_stb;
  assign mem_sel = 16'hFFFF;

endmodule
